// File: rtl/xram_pkg.sv
// Shared types and helpers for the external asynchronous SRAM controller.
package xram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        HOLD,
        DONE
    } state_e;

    localparam int WCNT_W = 4;

    function automatic int NB(input int dw);
        return 32 / dw;
    endfunction

    function automatic int BSH(input int dw);
        return (dw == 16) ? 1 : 0;
    endfunction

endpackage

// File: rtl/xram_ctrl.sv
// External async SRAM controller: splits a 32-bit CPU access into DW-wide beats
// with registered strobes, wait states, write hold and pad turnaround.
module xram_ctrl
    import xram_pkg::*;
#(
    parameter int AW      = 19,
    parameter int DW      = 16,
    parameter int WAIT_RD = 2,
    parameter int WAIT_WR = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    input  logic                   req_we,
    input  logic [AW+BSH(DW)-1:0]  req_addr,
    input  logic [31:0]            req_wdata,
    input  logic [3:0]             req_wstrb,
    output logic                   ready,
    output logic [31:0]            rdata,
    output logic                   busy,
    output logic [AW-1:0]          xa,
    output logic [DW-1:0]          xdo,
    input  logic [DW-1:0]          xdi,
    output logic                   xd_oe,
    output logic                   xce_n,
    output logic                   xoe_n,
    output logic                   xwe_n,
    output logic [DW/8-1:0]        xbe_n
);

    localparam int NBEATS = NB(DW);
    localparam int BSHIFT = BSH(DW);
    localparam int BPB    = DW / 8;

    state_e              state_q, state_d;
    logic [1:0]          beat_q, beat_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic                we_q, we_d;
    logic [AW-1:0]       base_q, base_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          wstrb_q, wstrb_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [AW-1:0]       xa_q, xa_d;
    logic [DW-1:0]       xdo_q, xdo_d;
    logic [BPB-1:0]      xbe_n_q, xbe_n_d;
    logic                xce_n_q, xce_n_d, xoe_n_q, xoe_n_d, xwe_n_q, xwe_n_d;
    logic                xd_oe_q, xd_oe_d, ready_q, ready_d, busy_q, busy_d;
    logic [2:0]          nxt;
    logic                active;

    function automatic logic [BPB-1:0] beat_strb(input logic [3:0] strb, input int k);
        return strb[k*BPB +: BPB];
    endfunction

    // {found, index} of the first beat at or after 'from'; writes skip empty-strobe beats
    function automatic logic [2:0] next_beat(input logic we, input logic [3:0] strb, input int from);
        logic [2:0] r;
        r = '0;
        for (int k = NBEATS - 1; k >= 0; k--) begin
            if (k >= from && (!we || beat_strb(strb, k) != '0)) r = {1'b1, k[1:0]};
        end
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        wcnt_d  = wcnt_q;
        we_d    = we_q;
        base_d  = base_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        nxt     = '0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    base_d  = AW'(req_addr >> BSHIFT) & ~AW'(NBEATS - 1);
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    nxt     = next_beat(req_we, req_wstrb, 0);
                    state_d = nxt[2] ? SETUP : DONE;
                    beat_d  = nxt[1:0];
                end
            end
            SETUP: begin
                state_d = ACCESS;
                wcnt_d  = we_q ? WCNT_W'(WAIT_WR) : WCNT_W'(WAIT_RD);
            end
            ACCESS: begin
                if (wcnt_q != '0) begin
                    wcnt_d = wcnt_q - 1'b1;
                end else if (we_q) begin
                    state_d = HOLD;
                end else begin
                    rdata_d[beat_q*DW +: DW] = xdi;
                    nxt     = next_beat(1'b0, wstrb_q, int'(beat_q) + 1);
                    state_d = nxt[2] ? SETUP : DONE;
                    beat_d  = nxt[1:0];
                end
            end
            HOLD: begin
                nxt     = next_beat(1'b1, wstrb_q, int'(beat_q) + 1);
                state_d = nxt[2] ? SETUP : DONE;
                beat_d  = nxt[1:0];
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Pad outputs are decoded from the next state so every strobe is a flop
        active  = (state_d == SETUP) || (state_d == ACCESS) || (state_d == HOLD);
        xce_n_d = !active;
        xoe_n_d = !(state_d == ACCESS && !we_d);
        xwe_n_d = !(state_d == ACCESS && we_d);
        xd_oe_d = active && we_d;
        xbe_n_d = '1;
        if (active) xbe_n_d = we_d ? ~beat_strb(wstrb_d, int'(beat_d)) : '0;
        xa_d  = xa_q;
        xdo_d = xdo_q;
        if (state_d == SETUP) begin
            xa_d = base_d + AW'(beat_d);
            if (we_d) xdo_d = wdata_d[beat_d*DW +: DW];
        end
        ready_d = (state_d == DONE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            wcnt_q  <= '0;
            rdata_q <= '0;
            xa_q    <= '0;
            xdo_q   <= '0;
            xbe_n_q <= '1;
            xce_n_q <= 1'b1;
            xoe_n_q <= 1'b1;
            xwe_n_q <= 1'b1;
            xd_oe_q <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            wcnt_q  <= wcnt_d;
            rdata_q <= rdata_d;
            xa_q    <= xa_d;
            xdo_q   <= xdo_d;
            xbe_n_q <= xbe_n_d;
            xce_n_q <= xce_n_d;
            xoe_n_q <= xoe_n_d;
            xwe_n_q <= xwe_n_d;
            xd_oe_q <= xd_oe_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    // Latched request fields are only meaningful while a transfer is in flight
    always_ff @(posedge clk) begin
        we_q    <= we_d;
        base_q  <= base_d;
        wdata_q <= wdata_d;
        wstrb_q <= wstrb_d;
    end

    assign ready = ready_q;
    assign rdata = rdata_q;
    assign busy  = busy_q;
    assign xa    = xa_q;
    assign xdo   = xdo_q;
    assign xd_oe = xd_oe_q;
    assign xce_n = xce_n_q;
    assign xoe_n = xoe_n_q;
    assign xwe_n = xwe_n_q;
    assign xbe_n = xbe_n_q;

endmodule
